// File: rtl/lfsr_stream.sv
// Galois right-shift LFSR stream generator: STEPS steps per word on a valid/ready stream,
// with seed load, zero-seed substitution, accepted-word counter and period-wrap pulse.
module lfsr_stream #(
  parameter int               WIDTH        = 16,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [STEPS-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      word_count,
  output logic             wrap_pulse,
  output logic             seed_err,
  output logic [WIDTH-1:0] state_out
);

  if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
    $error("lfsr_stream: WIDTH=%0d outside 3..64", WIDTH);
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_stream: STEPS=%0d outside 1..WIDTH", STEPS);
  end

  function automatic logic [63:0] t_bit(input int t);
    return 64'd1 << (t - 1);
  endfunction

  // XAPP052 maximal-length tap sets, tap n mapped to state bit n-1
  function automatic logic [63:0] tap_mask(input int w);
    logic [63:0] m;
    m = '0;
    case (w)
      3:  m = t_bit(3)  | t_bit(2);
      4:  m = t_bit(4)  | t_bit(3);
      5:  m = t_bit(5)  | t_bit(3);
      6:  m = t_bit(6)  | t_bit(5);
      7:  m = t_bit(7)  | t_bit(6);
      8:  m = t_bit(8)  | t_bit(6)  | t_bit(5)  | t_bit(4);
      9:  m = t_bit(9)  | t_bit(5);
      10: m = t_bit(10) | t_bit(7);
      11: m = t_bit(11) | t_bit(9);
      12: m = t_bit(12) | t_bit(6)  | t_bit(4)  | t_bit(1);
      13: m = t_bit(13) | t_bit(4)  | t_bit(3)  | t_bit(1);
      14: m = t_bit(14) | t_bit(5)  | t_bit(3)  | t_bit(1);
      15: m = t_bit(15) | t_bit(14);
      16: m = t_bit(16) | t_bit(15) | t_bit(13) | t_bit(4);
      17: m = t_bit(17) | t_bit(14);
      18: m = t_bit(18) | t_bit(11);
      19: m = t_bit(19) | t_bit(6)  | t_bit(2)  | t_bit(1);
      20: m = t_bit(20) | t_bit(17);
      21: m = t_bit(21) | t_bit(19);
      22: m = t_bit(22) | t_bit(21);
      23: m = t_bit(23) | t_bit(18);
      24: m = t_bit(24) | t_bit(23) | t_bit(22) | t_bit(17);
      25: m = t_bit(25) | t_bit(22);
      26: m = t_bit(26) | t_bit(6)  | t_bit(2)  | t_bit(1);
      27: m = t_bit(27) | t_bit(5)  | t_bit(2)  | t_bit(1);
      28: m = t_bit(28) | t_bit(25);
      29: m = t_bit(29) | t_bit(27);
      30: m = t_bit(30) | t_bit(6)  | t_bit(4)  | t_bit(1);
      31: m = t_bit(31) | t_bit(28);
      32: m = t_bit(32) | t_bit(22) | t_bit(2)  | t_bit(1);
      33: m = t_bit(33) | t_bit(20);
      34: m = t_bit(34) | t_bit(27) | t_bit(2)  | t_bit(1);
      35: m = t_bit(35) | t_bit(33);
      36: m = t_bit(36) | t_bit(25);
      37: m = t_bit(37) | t_bit(5)  | t_bit(4)  | t_bit(3) | t_bit(2) | t_bit(1);
      38: m = t_bit(38) | t_bit(6)  | t_bit(5)  | t_bit(1);
      39: m = t_bit(39) | t_bit(35);
      40: m = t_bit(40) | t_bit(38) | t_bit(21) | t_bit(19);
      41: m = t_bit(41) | t_bit(38);
      42: m = t_bit(42) | t_bit(41) | t_bit(20) | t_bit(19);
      43: m = t_bit(43) | t_bit(42) | t_bit(38) | t_bit(37);
      44: m = t_bit(44) | t_bit(43) | t_bit(18) | t_bit(17);
      45: m = t_bit(45) | t_bit(44) | t_bit(42) | t_bit(41);
      46: m = t_bit(46) | t_bit(45) | t_bit(26) | t_bit(25);
      47: m = t_bit(47) | t_bit(42);
      48: m = t_bit(48) | t_bit(47) | t_bit(21) | t_bit(20);
      49: m = t_bit(49) | t_bit(40);
      50: m = t_bit(50) | t_bit(49) | t_bit(24) | t_bit(23);
      51: m = t_bit(51) | t_bit(50) | t_bit(36) | t_bit(35);
      52: m = t_bit(52) | t_bit(49);
      53: m = t_bit(53) | t_bit(52) | t_bit(38) | t_bit(37);
      54: m = t_bit(54) | t_bit(53) | t_bit(18) | t_bit(17);
      55: m = t_bit(55) | t_bit(31);
      56: m = t_bit(56) | t_bit(55) | t_bit(35) | t_bit(34);
      57: m = t_bit(57) | t_bit(50);
      58: m = t_bit(58) | t_bit(39);
      59: m = t_bit(59) | t_bit(58) | t_bit(38) | t_bit(37);
      60: m = t_bit(60) | t_bit(59);
      61: m = t_bit(61) | t_bit(60) | t_bit(46) | t_bit(45);
      62: m = t_bit(62) | t_bit(61) | t_bit(6)  | t_bit(5);
      63: m = t_bit(63) | t_bit(62);
      64: m = t_bit(64) | t_bit(63) | t_bit(61) | t_bit(60);
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [WIDTH-1:0] TAP       = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] SEED_INIT = (SEED_DEFAULT == '0) ? WIDTH'(1) : SEED_DEFAULT;
  localparam logic             SEED_ZERO = (SEED_DEFAULT == '0);

  typedef enum logic {S_IDLE = 1'b0, S_FULL = 1'b1} fsm_t;

  fsm_t             r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_seed;
  logic [STEPS-1:0] r_data;
  logic [31:0]      r_count;
  logic             r_wrap;
  logic             r_seed_err;

  logic [WIDTH-1:0] w_nxt;
  logic [STEPS-1:0] w_bits;
  logic [WIDTH-1:0] w_seed_sub;
  logic             w_accept;
  logic             w_fill;

  // Unrolled STEPS-step advance; each step's shifted-out LSB becomes one output bit
  always_comb begin
    w_nxt  = r_state;
    w_bits = '0;
    for (int i = 0; i < STEPS; i++) begin
      w_bits[i] = w_nxt[0];
      w_nxt     = (w_nxt >> 1) ^ (w_nxt[0] ? TAP : '0);
    end
  end

  assign w_seed_sub = (seed_in == '0) ? WIDTH'(1) : seed_in;
  assign w_accept   = (r_fsm == S_FULL) && out_ready;
  assign w_fill     = enable && ((r_fsm == S_IDLE) || out_ready) && !load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      r_state    <= SEED_INIT;
      r_seed     <= SEED_INIT;
      r_data     <= '0;
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_seed_err <= SEED_ZERO;
    end else if (load) begin
      // Load wins over fill and accept; a pending word is dropped uncounted
      r_fsm      <= S_IDLE;
      r_state    <= w_seed_sub;
      r_seed     <= w_seed_sub;
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_seed_err <= (seed_in == '0);
    end else begin
      if (w_accept) begin
        r_count <= r_count + 32'd1;
      end
      if (w_fill) begin
        r_fsm   <= S_FULL;
        r_data  <= w_bits;
        r_state <= w_nxt;
        r_wrap  <= (w_nxt == r_seed);
      end else begin
        r_wrap <= 1'b0;
        if (w_accept) begin
          r_fsm <= S_IDLE;
        end
      end
    end
  end

  assign out_data   = r_data;
  assign out_valid  = (r_fsm == S_FULL);
  assign word_count = r_count;
  assign wrap_pulse = r_wrap;
  assign seed_err   = r_seed_err;
  assign state_out  = r_state;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench for lfsr_stream: three instances (4/1, 4/4, 64/64) driven with random
// enable/ready, loads and a mid-stream reset, checked against a step-by-step LFSR model.
module tb_lfsr_stream;

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] st;
    logic        wrap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        en   [3];
  logic        ld   [3];
  logic        rdy  [3];
  logic [63:0] seed [3];
  logic        ov   [3];
  logic        wp   [3];
  logic        se   [3];
  logic [31:0] wc   [3];
  logic [63:0] odx  [3];
  logic [63:0] sox  [3];

  logic [0:0]  od0;
  logic [3:0]  od1;
  logic [63:0] od2;
  logic [3:0]  so0, so1;
  logic [63:0] so2;

  exp_t q [3][$];
  int   n_chk  = 0;
  int   n_fail = 0;

  lfsr_stream #(.WIDTH(4), .STEPS(1), .SEED_DEFAULT(4'h0)) u0 (
    .clk(clk), .rst(rst[0]), .enable(en[0]), .load(ld[0]), .seed_in(seed[0][3:0]),
    .out_data(od0), .out_valid(ov[0]), .out_ready(rdy[0]), .word_count(wc[0]),
    .wrap_pulse(wp[0]), .seed_err(se[0]), .state_out(so0));

  lfsr_stream #(.WIDTH(4), .STEPS(4), .SEED_DEFAULT(4'h1)) u1 (
    .clk(clk), .rst(rst[1]), .enable(en[1]), .load(ld[1]), .seed_in(seed[1][3:0]),
    .out_data(od1), .out_valid(ov[1]), .out_ready(rdy[1]), .word_count(wc[1]),
    .wrap_pulse(wp[1]), .seed_err(se[1]), .state_out(so1));

  lfsr_stream #(.WIDTH(64), .STEPS(64), .SEED_DEFAULT(64'hACE1_2468_1357_9BDF)) u2 (
    .clk(clk), .rst(rst[2]), .enable(en[2]), .load(ld[2]), .seed_in(seed[2]),
    .out_data(od2), .out_valid(ov[2]), .out_ready(rdy[2]), .word_count(wc[2]),
    .wrap_pulse(wp[2]), .seed_err(se[2]), .state_out(so2));

  always_comb begin
    odx[0] = {63'b0, od0};
    odx[1] = {60'b0, od1};
    odx[2] = od2;
    sox[0] = {60'b0, so0};
    sox[1] = {60'b0, so1};
    sox[2] = so2;
  end

  function automatic logic [63:0] tap_of(input int d);
    return (d == 2) ? 64'hD800_0000_0000_0000 : 64'hC;
  endfunction

  function automatic int steps_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 64);
  endfunction

  function automatic logic [63:0] seeddef_of(input int d);
    return (d == 0) ? 64'h0 : ((d == 1) ? 64'h1 : 64'hACE1_2468_1357_9BDF);
  endfunction

  function automatic logic [63:0] sub(input logic [63:0] x);
    return (x == 64'h0) ? 64'h1 : x;
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp_v);
    end
  endtask

  // Expected stream for a seed: each word collects the LSB seen before every single step
  task automatic push_words(input int d, input logic [63:0] sd, input int n);
    logic [63:0] s, s0;
    exp_t e;
    q[d].delete();
    s0 = sub(sd);
    s  = s0;
    for (int k = 0; k < n; k++) begin
      e.data = '0;
      for (int i = 0; i < steps_of(d); i++) begin
        e.data[i] = s[0];
        s = (s >> 1) ^ (s[0] ? tap_of(d) : 64'h0);
      end
      e.st   = s;
      e.wrap = (s == s0);
      q[d].push_back(e);
    end
  endtask

  // Monitor: inputs seen at the falling edge are those that acted on the preceding rising edge
  logic pov [3];
  int   cnt [3];
  logic xse [3];
  exp_t cur [3];

  initial begin
    for (int d = 0; d < 3; d++) begin
      pov[d] = 1'b0;
      cnt[d] = 0;
      xse[d] = (seeddef_of(d) == 64'h0);
      cur[d] = '0;
    end
  end

  always @(negedge clk) begin : mon
    logic fill, acc, xov, wexp;
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        pov[d] = 1'b0;
        cnt[d] = 0;
        xse[d] = (seeddef_of(d) == 64'h0);
      end else begin
        fill = en[d] && (!pov[d] || rdy[d]) && !ld[d];
        acc  = pov[d] && rdy[d];
        wexp = 1'b0;
        if (ld[d]) begin
          xov    = 1'b0;
          cnt[d] = 0;
          xse[d] = (seed[d] == 64'h0);
          chk("load_state", d, sox[d], sub(seed[d]));
        end else begin
          if (acc) cnt[d]++;
          if (fill) begin
            if (q[d].size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL underflow dut%0d: got a word, expected none queued", d);
            end else begin
              cur[d] = q[d].pop_front();
              chk("state", d, sox[d], cur[d].st);
            end
            xov  = 1'b1;
            wexp = cur[d].wrap;
          end else begin
            xov = acc ? 1'b0 : pov[d];
          end
        end
        chk("valid", d, 64'(ov[d]), 64'(xov));
        chk("count", d, 64'(wc[d]), 64'(cnt[d]));
        chk("wrap", d, 64'(wp[d]), 64'(wexp));
        chk("seed_err", d, 64'(se[d]), 64'(xse[d]));
        if (xov) chk("data", d, odx[d], cur[d].data);
        pov[d] = xov;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input int d, input logic [63:0] sd, input int n);
    ld[d]   = 1'b1;
    seed[d] = sd;
    push_words(d, sd, n);
    tick();
    ld[d] = 1'b0;
  endtask

  task automatic run(input int d, input int cycles, input bit rnd);
    for (int c = 0; c < cycles; c++) begin
      en[d]  = rnd ? ($urandom_range(3) != 0) : 1'b1;
      rdy[d] = rnd ? $urandom_range(1) : 1'b1;
      tick();
    end
  endtask

  initial begin : stim
    int guard;
    for (int d = 0; d < 3; d++) begin
      rst[d]  = 1'b1;
      en[d]   = 1'b0;
      ld[d]   = 1'b0;
      rdy[d]  = 1'b0;
      seed[d] = '0;
      push_words(d, seeddef_of(d), (d == 2) ? 1200 : 200);
    end
    tick(); tick(); tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", d, 64'(ov[d]), 64'h0);
      chk("rst_count", d, 64'(wc[d]), 64'h0);
      chk("rst_state", d, sox[d], sub(seeddef_of(d)));
      chk("rst_seed_err", d, 64'(se[d]), 64'(seeddef_of(d) == 64'h0));
      rst[d] = 1'b0;
    end
    tick();

    // 4-bit, one step per word: full period, backpressure, zero seed, load over a live word
    do_load(0, 64'h1, 200);
    run(0, 40, 1'b0);
    rdy[0] = 1'b0;
    repeat (5) tick();
    run(0, 10, 1'b0);
    run(0, 100, 1'b1);
    do_load(0, 64'h0, 200);
    run(0, 30, 1'b0);
    do_load(0, 64'h5, 200);
    run(0, 20, 1'b1);
    en[0]  = 1'b1;
    rdy[0] = 1'b1;
    guard  = 0;
    while (!ov[0] && guard < 10) begin
      tick();
      guard++;
    end
    chk("live_word_before_load", 0, 64'(ov[0]), 64'h1);
    do_load(0, 64'h9, 200);
    run(0, 10, 1'b0);
    en[0] = 1'b0;

    // 4-bit, four steps per word
    do_load(1, 64'h1, 200);
    run(1, 40, 1'b0);
    run(1, 100, 1'b1);
    en[1] = 1'b0;

    // 64-bit, 64 steps per word: long run then asynchronous reset mid-stream
    do_load(2, {$urandom, $urandom}, 1200);
    run(2, 1000, 1'b0);
    run(2, 60, 1'b1);
    en[2]  = 1'b1;
    rdy[2] = 1'b1;
    rst[2] = 1'b1;
    #1;
    chk("async_rst_valid", 2, 64'(ov[2]), 64'h0);
    chk("async_rst_count", 2, 64'(wc[2]), 64'h0);
    chk("async_rst_state", 2, sox[2], seeddef_of(2));
    push_words(2, seeddef_of(2), 200);
    tick(); tick();
    rst[2] = 1'b0;
    run(2, 50, 1'b1);
    en[2] = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
